// File: rtl/cronometro_ctrl.sv
// Stopwatch controller: button conditioning, control FSM, centisecond time base and
// min/sec/cs counters with lap freeze and sticky overflow.
module cronometro_ctrl #(
   parameter int unsigned TICK_DIV   = 500000,
   parameter int unsigned DEB_CYCLES = 1000,
   parameter int unsigned MAX_MIN    = 59,
   parameter int unsigned MIN_W      = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             conta,
   input  logic             pausa,
   input  logic             para,
   input  logic             volta,
   output logic [2:0]       estado,
   output logic [6:0]       disp_cs,
   output logic [5:0]       disp_s,
   output logic [MIN_W-1:0] disp_m,
   output logic             lap_valid,
   output logic             overflow
);

   localparam int unsigned DW = $clog2(DEB_CYCLES + 1);
   localparam int unsigned PW = $clog2(TICK_DIV);

   typedef enum logic [2:0] {
      StInicio = 3'd0,
      StContar = 3'd1,
      StPausar = 3'd2,
      StParar  = 3'd3,
      StVolta  = 3'd4
   } state_e;

   // Button index: 0 para, 1 pausa, 2 volta, 3 conta (also the priority order).
   logic [3:0]    btn_raw;
   logic [3:0]    sync1_q, sync2_q, deb_q, deb_d, press_q;
   logic [DW-1:0] deb_cnt_q [4];
   logic [DW-1:0] deb_cnt_d [4];

   assign btn_raw = {conta, volta, pausa, para};

   always_comb begin
      for (int b = 0; b < 4; b++) begin
         deb_d[b]     = deb_q[b];
         deb_cnt_d[b] = '0;
         if (sync2_q[b] != deb_q[b]) begin
            if (deb_cnt_q[b] == DW'(DEB_CYCLES - 1)) deb_d[b] = sync2_q[b];
            else deb_cnt_d[b] = deb_cnt_q[b] + DW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         sync1_q <= '1;
         sync2_q <= '1;
         deb_q   <= '1;
         press_q <= '0;
         for (int b = 0; b < 4; b++) deb_cnt_q[b] <= '0;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
         deb_q   <= deb_d;
         press_q <= deb_q & ~deb_d;
         for (int b = 0; b < 4; b++) deb_cnt_q[b] <= deb_cnt_d[b];
      end
   end

   logic go_para, go_pausa, go_volta, go_conta;

   assign go_para  = press_q[0];
   assign go_pausa = press_q[1] & ~press_q[0];
   assign go_volta = press_q[2] & ~|press_q[1:0];
   assign go_conta = press_q[3] & ~|press_q[2:0];

   state_e            state_q, state_d;
   logic              lap_latch, restart, running, tick;
   logic [PW-1:0]     presc_q, presc_d;
   logic [6:0]        cs_q, cs_d, lap_cs_q, lap_cs_d;
   logic [5:0]        s_q, s_d, lap_s_q, lap_s_d;
   logic [MIN_W-1:0]  m_q, m_d, lap_m_q, lap_m_d;
   logic              ovf_q, ovf_d;

   always_comb begin
      state_d   = state_q;
      lap_latch = 1'b0;
      restart   = 1'b0;
      unique case (state_q)
         StInicio: if (go_conta) state_d = StContar;
         StContar: begin
            if (go_para) state_d = StParar;
            else if (go_pausa) state_d = StPausar;
            else if (go_volta) begin
               state_d   = StVolta;
               lap_latch = 1'b1;
            end
         end
         StVolta: begin
            if (go_para) state_d = StParar;
            else if (go_pausa) state_d = StPausar;
            else if (go_volta) state_d = StContar;
         end
         StPausar: begin
            if (go_para) state_d = StParar;
            else if (go_conta) state_d = StContar;
         end
         StParar: begin
            if (go_conta) begin
               state_d = StContar;
               restart = 1'b1;
            end
         end
         default: state_d = StInicio;
      endcase
   end

   assign running = (state_q == StContar) || (state_q == StVolta);
   assign tick    = running && (presc_q == PW'(TICK_DIV - 1));

   always_comb begin
      presc_d = presc_q;
      cs_d    = cs_q;
      s_d     = s_q;
      m_d     = m_q;
      ovf_d   = ovf_q;
      if (restart) begin
         presc_d = '0;
         cs_d    = '0;
         s_d     = '0;
         m_d     = '0;
         ovf_d   = 1'b0;
      end else if (tick) begin
         presc_d = '0;
         if (cs_q == 7'd99) begin
            cs_d = '0;
            if (s_q == 6'd59) begin
               s_d = '0;
               if (m_q == MIN_W'(MAX_MIN)) begin
                  m_d   = '0;
                  ovf_d = 1'b1;
               end else begin
                  m_d = m_q + MIN_W'(1);
               end
            end else begin
               s_d = s_q + 6'd1;
            end
         end else begin
            cs_d = cs_q + 7'd1;
         end
      end else if (running) begin
         presc_d = presc_q + PW'(1);
      end
   end

   // Lap captures the value before any coincident tick increment.
   assign lap_cs_d = lap_latch ? cs_q : lap_cs_q;
   assign lap_s_d  = lap_latch ? s_q  : lap_s_q;
   assign lap_m_d  = lap_latch ? m_q  : lap_m_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= StInicio;
         presc_q   <= '0;
         cs_q      <= '0;
         s_q       <= '0;
         m_q       <= '0;
         ovf_q     <= 1'b0;
         lap_cs_q  <= '0;
         lap_s_q   <= '0;
         lap_m_q   <= '0;
         lap_valid <= 1'b0;
         disp_cs   <= '0;
         disp_s    <= '0;
         disp_m    <= '0;
      end else begin
         state_q   <= state_d;
         presc_q   <= presc_d;
         cs_q      <= cs_d;
         s_q       <= s_d;
         m_q       <= m_d;
         ovf_q     <= ovf_d;
         lap_cs_q  <= lap_cs_d;
         lap_s_q   <= lap_s_d;
         lap_m_q   <= lap_m_d;
         lap_valid <= (state_d == StVolta);
         if (state_d == StVolta) begin
            disp_cs <= lap_cs_d;
            disp_s  <= lap_s_d;
            disp_m  <= lap_m_d;
         end else begin
            disp_cs <= cs_q;
            disp_s  <= s_q;
            disp_m  <= m_q;
         end
      end
   end

   assign estado   = state_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_cronometro_ctrl.sv
// Randomised bench for cronometro_ctrl: a reference model built from elapsed running
// cycles pushes the expected outputs each cycle; a monitor pops and compares them.
module tb_cronometro_ctrl;

   localparam int TD   = 4;
   localparam int DEB  = 3;
   localparam int MAXM = 1;
   localparam int MW   = 8;
   localparam int HW   = DEB + 2;
   localparam int WRAP = (MAXM + 1) * 6000;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [3:0]    btn = 4'hF;  // 0 para, 1 pausa, 2 volta, 3 conta; 1 = released
   logic [2:0]    estado;
   logic [6:0]    disp_cs;
   logic [5:0]    disp_s;
   logic [MW-1:0] disp_m;
   logic          lap_valid, overflow;

   int n_cmp = 0;
   int n_bad = 0;

   cronometro_ctrl #(
      .TICK_DIV(TD), .DEB_CYCLES(DEB), .MAX_MIN(MAXM), .MIN_W(MW)
   ) dut (
      .clk(clk), .reset(reset),
      .conta(btn[3]), .pausa(btn[1]), .para(btn[0]), .volta(btn[2]),
      .estado(estado), .disp_cs(disp_cs), .disp_s(disp_s), .disp_m(disp_m),
      .lap_valid(lap_valid), .overflow(overflow)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [25:0]    exp_q[$];
   logic [HW-1:0]  hist [4];
   logic [DEB-1:0] win;
   logic [3:0]     m_deb = 4'hF, m_pulse = 4'h0, np;
   logic           nd;
   int m_state = 0, m_run = 0, m_lap = 0, pre, sel, ns;

   function automatic logic [25:0] pack(input int st, input int t, input bit lv, input bit ov);
      int v;
      v = t % WRAP;
      return {3'(st), 7'(v % 100), 6'((v / 100) % 60), 8'(v / 6000), lv, ov};
   endfunction

   function automatic int ticks();
      return m_run / TD;
   endfunction

   initial begin : model
      forever begin
         @(posedge clk);
         if (!reset) begin
            for (int b = 0; b < 4; b++) hist[b] = '1;
            m_deb = 4'hF; m_pulse = 4'h0; m_state = 0; m_run = 0; m_lap = 0;
            exp_q.push_back(pack(0, 0, 1'b0, 1'b0));
         end else begin
            for (int b = 0; b < 4; b++) begin
               hist[b] = {hist[b][HW-2:0], btn[b]};
               win = hist[b][HW-1:2];  // last DEB samples seen past the synchroniser
               nd = m_deb[b];
               if (win == '0) nd = 1'b0;
               else if (win == '1) nd = 1'b1;
               np[b] = m_deb[b] & ~nd;
               m_deb[b] = nd;
            end
            sel = m_pulse[0] ? 0 : m_pulse[1] ? 1 : m_pulse[2] ? 2 : m_pulse[3] ? 3 : -1;
            pre = m_run / TD;
            if (m_state == 1 || m_state == 4) m_run++;
            ns = m_state;
            case (m_state)
               0: if (sel == 3) ns = 1;
               1: begin
                  if (sel == 0) ns = 3;
                  else if (sel == 1) ns = 2;
                  else if (sel == 2) begin ns = 4; m_lap = pre; end
               end
               4: begin
                  if (sel == 0) ns = 3;
                  else if (sel == 1) ns = 2;
                  else if (sel == 2) ns = 1;
               end
               2: begin
                  if (sel == 0) ns = 3;
                  else if (sel == 3) ns = 1;
               end
               3: if (sel == 3) begin ns = 1; m_run = 0; end
               default: ns = 0;
            endcase
            m_state = ns;
            m_pulse = np;
            exp_q.push_back(pack(ns, (ns == 4) ? m_lap : pre, ns == 4, (m_run / TD) >= WRAP));
         end
      end
   end

   // ---------------- monitor ----------------
   initial begin : monitor
      logic [25:0] e, a;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {estado, disp_cs, disp_s, disp_m, lap_valid, overflow};
            n_cmp++;
            if (a !== e) begin
               n_bad++;
               if (n_bad <= 30)
                  $display("FAIL outputs t=%0t got st=%0d %0d:%0d:%0d lv=%0b ov=%0b want st=%0d %0d:%0d:%0d lv=%0b ov=%0b",
                           $time, a[25:23], a[9:2], a[15:10], a[22:16], a[1], a[0],
                           e[25:23], e[9:2], e[15:10], e[22:16], e[1], e[0]);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic press(input logic [3:0] mask, input int hold, input int rel);
      btn = btn & ~mask;
      cyc(hold);
      btn = btn | mask;
      cyc(rel);
   endtask

   task automatic check(input string name, input int act, input int want);
      n_cmp++;
      if (act != want) begin
         n_bad++;
         $display("FAIL %s got %0d want %0d", name, act, want);
      end
   endtask

   task automatic wait_ticks(input int t, input int limit);
      int n;
      n = 0;
      while (ticks() < t && n < limit) begin cyc(1); n++; end
      n_cmp++;
      if (ticks() < t) begin
         n_bad++;
         $display("FAIL wait_ticks got %0d want %0d", ticks(), t);
      end
   endtask

   initial begin : stim
      logic [3:0] mask;
      // 1: reset, start, count past one second
      cyc(3);
      reset = 1'b1;
      check("reset_estado", int'(estado), 0);
      check("reset_disp", int'(disp_cs) + int'(disp_s) + int'(disp_m), 0);
      press(4'b1000, 10, 10);
      check("start_estado", int'(estado), 1);
      wait_ticks(101, 1000);
      // 2: restart, pause near 0:00:50, hold, resume
      press(4'b0001, 10, 10);
      check("stop_estado", int'(estado), 3);
      press(4'b1000, 10, 10);
      wait_ticks(48, 1000);
      press(4'b0010, 10, 10);
      check("pause_estado", int'(estado), 2);
      cyc(200);
      press(4'b1000, 10, 10);
      check("resume_estado", int'(estado), 1);
      // 3: lap freeze while live time runs
      press(4'b0001, 10, 10);
      press(4'b1000, 10, 10);
      wait_ticks(18, 1000);
      press(4'b0100, 10, 10);
      check("lap_estado", int'(estado), 4);
      check("lap_valid", int'(lap_valid), 1);
      cyc(80);
      press(4'b0100, 10, 10);
      check("unlap_estado", int'(estado), 1);
      check("unlap_valid", int'(lap_valid), 0);
      // 4: stop around 0:05:00, then restart
      wait_ticks(500, 4000);
      press(4'b0001, 10, 10);
      check("stop2_estado", int'(estado), 3);
      cyc(100);
      press(4'b1000, 10, 10);
      check("restart_estado", int'(estado), 1);
      check("restart_ovf", int'(overflow), 0);
      // 5: run past MAX_MIN:59:99, then reset mid-count
      wait_ticks(WRAP + 3, 60000);
      check("overflow_set", int'(overflow), 1);
      cyc(20);
      check("overflow_sticky", int'(overflow), 1);
      reset = 1'b0;
      cyc(1);
      reset = 1'b1;
      check("midreset_estado", int'(estado), 0);
      check("midreset_ovf", int'(overflow), 0);
      check("midreset_disp", int'(disp_cs) + int'(disp_s) + int'(disp_m), 0);
      // 6: pausa+para together, then a short glitch on conta
      press(4'b1000, 10, 10);
      wait_ticks(30, 1000);
      press(4'b0011, 10, 10);
      check("para_priority", int'(estado), 3);
      press(4'b1000, 2, 10);
      check("glitch_ignored", int'(estado), 3);
      // random phase
      for (int i = 0; i < 80; i++) begin
         if ($urandom_range(15) == 0) begin
            reset = 1'b0;
            cyc(1);
            reset = 1'b1;
         end
         mask = 4'($urandom_range(15));
         if (mask == 4'h0) mask = 4'b1000;
         press(mask, $urandom_range(1, 8), $urandom_range(0, 8));
         cyc($urandom_range(0, 40));
      end
      cyc(5);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
